bkg_map_arbiter: RTL and testbench

//  Shares the single background tile-map ROM port (9-bit addr, 3-bit tile code, 20x15 map) between
//  two requesters: the VGA renderer (streaming, latency-critical) and the game-logic collision query
//  (occasional, req/ack handshake). Converts (col,row) to a linear address, registers the ROM output,
//  and returns each tile code to the port that asked for it. Sits between the VGA renderer, the game logic and bkg_romN.

---
 rtl/bkg_pkg.sv | 28 ++
 rtl/bkg_addr_calc.sv | 23 ++
 rtl/bkg_map_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bkg_map_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bkg_pkg.sv
// Shared definitions for the background tile-map arbiter: map geometry,
// special tile codes, ROM owner tags and the logic-query FSM states.
package bkg_pkg;

  // Map geometry; widths match the 5-bit column and 4-bit row inputs
  localparam logic [4:0] MAP_W = 5'd20;
  localparam logic [3:0] MAP_H = 4'd15;

  // Tile codes with fixed meaning; an off-map lookup reads back as a wall
  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_WALL  = 3'd1;

  // Which requester owns the ROM access launched in a given cycle
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_RD,
    OWN_LG
  } owner_t;

  // Progress of a single game-logic query
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ISSUED,
    ACK
  } lg_state_t;

endpackage

// File: rtl/bkg_addr_calc.sv
// Combinational (col,row) -> linear tile-map address with an on-map flag.
// The row*20 product is built from two shifts so no multiplier is needed.
module bkg_addr_calc
  import bkg_pkg::*;
(
  input  logic [4:0] i_col,
  input  logic [3:0] i_row,
  output logic       o_in_range,
  output logic [8:0] o_addr
);

  logic [8:0] w_rowX16;
  logic [8:0] w_rowX4;

  // row*16 + row*4 + col; the largest on-map result is 299, so 9 bits never wrap
  always_comb begin
    w_rowX16   = {1'b0, i_row, 4'b0000};
    w_rowX4    = {3'b000, i_row, 2'b00};
    o_addr     = w_rowX16 + w_rowX4 + {4'b0000, i_col};
    o_in_range = (i_col < MAP_W) && (i_row < MAP_H);
  end

endmodule

// File: rtl/bkg_map_arbiter.sv
// Shares the background tile-map ROM between the VGA renderer (streaming,
// always preferred) and game-logic collision queries (req/ack handshake).
// A logic query deferred too long is forced through, displacing one
// renderer fetch. Optional statistics outputs are enabled by defining
// BKG_ARB_STATS_EN.
module bkg_map_arbiter
  import bkg_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 3,
  parameter int MAX_WAIT = 8
)
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req,
  input  logic [4:0]        i_rd_col,
  input  logic [3:0]        i_rd_row,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_tile,
  output logic              o_rd_drop,
  input  logic              i_lg_req,
  input  logic [4:0]        i_lg_col,
  input  logic [3:0]        i_lg_row,
  output logic              o_lg_ack,
  output logic [DATA_W-1:0] o_lg_tile,
  output logic [ADDR_W-1:0] o_rom_addr,
`ifdef BKG_ARB_STATS_EN
  output logic [15:0]       o_stat_drop,
  output logic [3:0]        o_stat_maxwait,
`endif
  input  logic [DATA_W-1:0] i_rom_q
);

  localparam int WAIT_W = 4;

  lg_state_t         r_state;
  lg_state_t         w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_nextWaitCnt;
  owner_t            w_grant;
  logic              w_force;
  logic              w_drop;

  logic              w_rdInRange;
  logic [8:0]        w_rdAddr;
  logic              w_lgInRange;
  logic [8:0]        w_lgAddr;
  logic              w_selInRange;
  logic [8:0]        w_selAddr;

  owner_t            r_owner;
  logic              r_outOfRange;
  logic              r_dropPend;

  bkg_addr_calc u_rdAddr (
    .i_col      (i_rd_col),
    .i_row      (i_rd_row),
    .o_in_range (w_rdInRange),
    .o_addr     (w_rdAddr)
  );

  bkg_addr_calc u_lgAddr (
    .i_col      (i_lg_col),
    .i_row      (i_lg_row),
    .o_in_range (w_lgInRange),
    .o_addr     (w_lgAddr)
  );

  // The address and range flag follow whichever requester won this cycle
  assign w_selInRange = (w_grant == OWN_LG) ? w_lgInRange : w_rdInRange;
  assign w_selAddr    = (w_grant == OWN_LG) ? w_lgAddr    : w_rdAddr;

  // Logic FSM state and its deferral counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
    end
  end

  // Arbitration plus FSM next state: the renderer wins unless the pending
  // query has waited its full allowance, in which case it is forced through
  always_comb begin
    w_grant       = OWN_NONE;
    w_drop        = 1'b0;
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_force       = (r_state == WAIT) && (r_waitCnt == WAIT_W'(MAX_WAIT - 1));

    if (w_force) begin
      w_grant = OWN_LG;
      w_drop  = i_rd_req;
    end else if (i_rd_req) begin
      w_grant = OWN_RD;
    end else if (r_state == WAIT) begin
      w_grant = OWN_LG;
    end

    case (r_state)
      IDLE: begin
        if (i_lg_req) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (w_grant == OWN_LG) begin
          w_nextState   = ISSUED;
          w_nextWaitCnt = '0;
        end else begin
          w_nextWaitCnt = r_waitCnt + 1'b1;
        end
      end
      ISSUED: w_nextState = ACK;
      ACK:    w_nextState = IDLE;
      default: begin
        w_nextState   = IDLE;
        w_nextWaitCnt = '0;
      end
    endcase
  end

  // Launch stage: register the ROM address and tag who the access is for;
  // off-map or idle cycles leave the ROM address where it was
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner      <= OWN_NONE;
      r_outOfRange <= 1'b0;
      r_dropPend   <= 1'b0;
      o_rom_addr   <= '0;
    end else begin
      r_owner      <= w_grant;
      r_outOfRange <= !w_selInRange;
      r_dropPend   <= w_drop;
      if ((w_grant != OWN_NONE) && w_selInRange) begin
        o_rom_addr <= ADDR_W'(w_selAddr);
      end
    end
  end

  // Return stage: capture ROM data (or a wall for off-map lookups) into the
  // owner's output; the drop pulse lines up with the displaced rd_valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_valid <= 1'b0;
      o_rd_tile  <= '0;
      o_rd_drop  <= 1'b0;
      o_lg_ack   <= 1'b0;
      o_lg_tile  <= '0;
    end else begin
      o_rd_valid <= (r_owner == OWN_RD);
      o_rd_drop  <= r_dropPend;
      o_lg_ack   <= (r_owner == OWN_LG);
      if (r_owner == OWN_RD) begin
        o_rd_tile <= r_outOfRange ? DATA_W'(TILE_WALL) : i_rom_q;
      end
      if (r_owner == OWN_LG) begin
        o_lg_tile <= r_outOfRange ? DATA_W'(TILE_WALL) : i_rom_q;
      end
    end
  end

`ifdef BKG_ARB_STATS_EN
  // Saturating count of displaced renderer fetches and the longest deferral seen
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_drop    <= '0;
      o_stat_maxwait <= '0;
    end else begin
      if (o_rd_drop && (o_stat_drop != 16'hFFFF)) begin
        o_stat_drop <= o_stat_drop + 16'd1;
      end
      if (r_waitCnt > o_stat_maxwait) begin
        o_stat_maxwait <= r_waitCnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bkg_map_arbiter.sv
// Directed bench for bkg_map_arbiter: renderer latency, logic query
// handshake, forced grant with renderer drop, off-map lookups and reset
// in the middle of a query. Statistics checks run when BKG_ARB_STATS_EN
// is defined.
module tb_bkg_map_arbiter;

  logic       clock;
  logic       reset;
  logic       rdReq;
  logic [4:0] rdCol;
  logic [3:0] rdRow;
  logic       rdValid;
  logic [2:0] rdTile;
  logic       rdDrop;
  logic       lgReq;
  logic [4:0] lgCol;
  logic [3:0] lgRow;
  logic       lgAck;
  logic [2:0] lgTile;
  logic [8:0] romAddr;
  logic [2:0] romQ;
`ifdef BKG_ARB_STATS_EN
  logic [15:0] statDrop;
  logic [3:0]  statMaxWait;
`endif

  int compareCount = 0;
  int failCount    = 0;

  bkg_map_arbiter dut (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_rd_req   (rdReq),
    .i_rd_col   (rdCol),
    .i_rd_row   (rdRow),
    .o_rd_valid (rdValid),
    .o_rd_tile  (rdTile),
    .o_rd_drop  (rdDrop),
    .i_lg_req   (lgReq),
    .i_lg_col   (lgCol),
    .i_lg_row   (lgRow),
    .o_lg_ack   (lgAck),
    .o_lg_tile  (lgTile),
    .o_rom_addr (romAddr),
`ifdef BKG_ARB_STATS_EN
    .o_stat_drop    (statDrop),
    .o_stat_maxwait (statMaxWait),
`endif
    .i_rom_q    (romQ)
  );

  // Free-running clock, 10 time units per period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Small ROM image: a few hand-picked tiles, everything else 2 or 3 by address parity
  function automatic logic [2:0] romModel(input logic [8:0] addr);
    case (addr)
      9'd5, 9'd48, 9'd285: romModel = 3'd1;
      9'd40:               romModel = 3'd0;
      default:             romModel = {2'b01, addr[0]};
    endcase
  endfunction

  // Combinational ROM behind the arbiter's registered address
  always_comb romQ = romModel(romAddr);

  // Advance one clock and settle just after the active edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive both request ports in one call
  task automatic applyStimulus(input logic rq, input logic [4:0] rc, input logic [3:0] rr,
                               input logic lq, input logic [4:0] lc, input logic [3:0] lr);
    rdReq = rq;
    rdCol = rc;
    rdRow = rr;
    lgReq = lq;
    lgCol = lc;
    lgRow = lr;
  endtask

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Renderer streams col=1,row=1 (tile 3) while a logic query for col=5,row=14
  // waits; it is forced through on the 9th edge and acked on the 10th
  task automatic forcedQuery();
    int ackIdx    = -1;
    int dropIdx   = -1;
    int dropCount = 0;
    int validCnt  = 0;
    applyStimulus(1'b1, 5'd1, 4'd1, 1'b1, 5'd5, 4'd14);
    for (int idx = 0; idx < 10; idx++) begin
      tick();
      if (idx == 8) checkOutput("forced rom_addr", romAddr, 285);
      if (rdValid) validCnt++;
      if (rdDrop) begin
        dropCount++;
        if (dropIdx < 0) dropIdx = idx;
      end
      if (lgAck && ackIdx < 0) begin
        ackIdx = idx;
        lgReq  = 1'b0;
      end
    end
    checkOutput("forced ack edge", ackIdx, 9);
    checkOutput("forced lg_tile", lgTile, 1);
    checkOutput("forced drop edge", dropIdx, 9);
    checkOutput("forced drop count", dropCount, 1);
    checkOutput("forced rd_valid count", validCnt, 8);
    tick();
    checkOutput("resume rd_valid", rdValid, 1);
    checkOutput("resume rd_tile", rdTile, 3);
    checkOutput("resume rd_drop", rdDrop, 0);
    checkOutput("resume lg_ack", lgAck, 0);
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset rd_valid", rdValid, 0);
    checkOutput("reset rd_tile", rdTile, 0);
    checkOutput("reset rd_drop", rdDrop, 0);
    checkOutput("reset lg_ack", lgAck, 0);
    checkOutput("reset lg_tile", lgTile, 0);
    checkOutput("reset rom_addr", romAddr, 0);

    // Renderer fetch col=5,row=0: address after one edge, data after two
    applyStimulus(1'b1, 5'd5, 4'd0, 1'b0, 5'd0, 4'd0);
    tick();
    checkOutput("rd rom_addr", romAddr, 5);
    checkOutput("rd early valid", rdValid, 0);
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    tick();
    checkOutput("rd valid", rdValid, 1);
    checkOutput("rd tile", rdTile, 1);
    tick();
    checkOutput("rd valid pulse", rdValid, 0);

    // Logic query col=8,row=2 with an idle renderer: ack on the third edge
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 5'd8, 4'd2);
    tick();
    checkOutput("lg ack early1", lgAck, 0);
    tick();
    checkOutput("lg rom_addr 48", romAddr, 48);
    checkOutput("lg ack early2", lgAck, 0);
    tick();
    checkOutput("lg ack", lgAck, 1);
    checkOutput("lg tile 48", lgTile, 1);
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 5'd8, 4'd2);
    tick();
    checkOutput("lg ack pulse", lgAck, 0);
    checkOutput("lg tile held", lgTile, 1);

    // Logic query col=0,row=2 reads the empty tile at address 40
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 5'd0, 4'd2);
    tick();
    tick();
    checkOutput("lg rom_addr 40", romAddr, 40);
    tick();
    checkOutput("lg ack 40", lgAck, 1);
    checkOutput("lg tile 40", lgTile, 0);
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    tick();

    // Off-map lookups on both ports return walls and leave the ROM address alone
    applyStimulus(1'b1, 5'd20, 4'd3, 1'b1, 5'd0, 4'd15);
    tick();
    checkOutput("oob rom_addr a", romAddr, 40);
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 5'd0, 4'd15);
    tick();
    checkOutput("oob rd_valid", rdValid, 1);
    checkOutput("oob rd_tile", rdTile, 1);
    checkOutput("oob rom_addr b", romAddr, 40);
    tick();
    checkOutput("oob lg_ack", lgAck, 1);
    checkOutput("oob lg_tile", lgTile, 1);
    checkOutput("oob rom_addr c", romAddr, 40);
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    tick();

    forcedQuery();
`ifdef BKG_ARB_STATS_EN
    forcedQuery();
    forcedQuery();
    checkOutput("stat_drop", statDrop, 3);
    checkOutput("stat_maxwait", statMaxWait, 7);
`endif

    // Reset while the query is in ISSUED: no ack, everything back to zero
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 5'd8, 4'd2);
    tick();
    tick();
    checkOutput("pre-reset rom_addr", romAddr, 48);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst lg_ack", lgAck, 0);
    checkOutput("midrst lg_tile", lgTile, 0);
    checkOutput("midrst rd_tile", rdTile, 0);
    checkOutput("midrst rd_valid", rdValid, 0);
    checkOutput("midrst rd_drop", rdDrop, 0);
    checkOutput("midrst rom_addr", romAddr, 0);
`ifdef BKG_ARB_STATS_EN
    checkOutput("midrst stat_drop", statDrop, 0);
`endif

    // A fresh query after reset is serviced normally (col=1,row=1 -> tile 3)
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 5'd1, 4'd1);
    tick();
    checkOutput("post-rst ack early", lgAck, 0);
    tick();
    checkOutput("post-rst rom_addr", romAddr, 21);
    tick();
    checkOutput("post-rst lg_ack", lgAck, 1);
    checkOutput("post-rst lg_tile", lgTile, 3);
    applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
